// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package im_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_W_DEFAULT = 8;

endpackage

// File: rtl/im_word_assembler.sv
// Packs accepted stream bytes big-endian into a 32-bit word and flags each completed word.
module im_word_assembler
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready,
    output logic        last_byte
);

    logic [1:0] byte_cnt;

    // Combinational so the loader can move to its write cycle on the same edge the 4th byte lands.
    assign last_byte = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            byte_cnt   <= '0;
            word_ready <= 1'b0;
        end else if (clear) begin
            word       <= '0;
            byte_cnt   <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= last_byte;
            if (shift_en) begin
                word     <= {word[23:0], byte_in};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/im_loader.sv
// Loads the instruction memory from a byte stream, one single-cycle write per word,
// holding the core in reset until the image is complete.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_wr,
    output logic [31:0]       im_wd,
    output logic [ADDR_W-1:0] im_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    output logic [31:0]       checksum
);

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(2 ** ADDR_W);
    localparam logic [LEN_W-1:0] ONE_WORD = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] wr_cnt;
    logic             start_ok;
    logic             asm_clear;
    logic             xfer;
    logic             last_byte;
    logic             word_ready;

    assign start_ok  = start && !abort && ((state == IDLE) || (state == DONE));
    assign asm_clear = abort || start_ok;
    assign xfer      = byte_valid && byte_ready;

    im_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .shift_en   (xfer),
        .byte_in    (byte_in),
        .word       (im_wd),
        .word_ready (word_ready),
        .last_byte  (last_byte)
    );

    // Abort outranks everything; im_wd stays put through WRITE because byte_ready is low there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            wr_cnt     <= '0;
            im_wr      <= 1'b0;
            im_addr    <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
            checksum   <= '0;
        end else if (abort) begin
            state      <= IDLE;
            im_wr      <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        checksum <= '0;
                        im_addr  <= '0;
                        wr_cnt   <= '0;
                        len_q    <= load_len;
                        cpu_hold <= 1'b1;
                        if (load_len == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (load_len > MAX_LEN) begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end else begin
                            state      <= RECV;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (last_byte) begin
                        state      <= WRITE;
                        im_wr      <= 1'b1;
                        byte_ready <= 1'b0;
                    end
                end
                WRITE: begin
                    im_wr   <= 1'b0;
                    im_addr <= im_addr + ADDR_W'(1);
                    wr_cnt  <= wr_cnt + ONE_WORD;
                    if (word_ready) begin
                        checksum <= checksum ^ im_wd;
                    end
                    if ((wr_cnt + ONE_WORD) == len_q) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as words are driven
// and popped by a write monitor that samples on the falling edge.
module tb_im_loader;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = ADDR_W + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [LEN_W-1:0]  load_len = '0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              im_wr;
    logic [31:0]       im_wd;
    logic [ADDR_W-1:0] im_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;
    logic [31:0]       checksum;

    int          compared = 0;
    int          mismatched = 0;
    int          writes_seen = 0;
    logic        prev_wr = 1'b0;
    logic [31:0] exp_sum = '0;
    wr_t         sb[$];
    logic [31:0] data_src[$];

    im_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_wr      (im_wr),
        .im_wd      (im_wd),
        .im_addr    (im_addr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every memory write is matched against the scoreboard and must last exactly one cycle.
    always @(negedge clk) begin
        wr_t e;
        if (im_wr === 1'b1) begin
            writes_seen <= writes_seen + 1;
            if (sb.size() == 0) begin
                checkOutput("spurious_wr", {31'd0, im_wr}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("wr_addr", {24'd0, im_addr}, {24'd0, e.addr});
                checkOutput("wr_data", im_wd, e.data);
            end
            checkOutput("rdy_in_wr", {31'd0, byte_ready}, 32'd0);
            if (prev_wr === 1'b1) checkOutput("wr_pulse", {31'd0, prev_wr}, 32'd0);
        end
        prev_wr <= im_wr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wr"},    {31'd0, im_wr},      32'd0);
        checkOutput({tag, "_wd"},    im_wd,               32'd0);
        checkOutput({tag, "_addr"},  {24'd0, im_addr},    32'd0);
        checkOutput({tag, "_rdy"},   {31'd0, byte_ready}, 32'd0);
        checkOutput({tag, "_busy"},  {31'd0, busy},       32'd0);
        checkOutput({tag, "_done"},  {31'd0, done},       32'd0);
        checkOutput({tag, "_err"},   {31'd0, err},        32'd0);
        checkOutput({tag, "_sum"},   checksum,            32'd0);
        checkOutput({tag, "_hold"},  {31'd0, cpu_hold},   32'd1);
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk);
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) checkOutput("rdy_timeout", {31'd0, byte_ready}, 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        for (int b = 0; b < 4; b++) begin
            sendByte(w[31 - 8*b -: 8]);
            if (b < 3) begin
                repeat (gap) begin
                    @(negedge clk);
                    checkOutput("rdy_gap", {31'd0, byte_ready}, 32'd1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        checkOutput("wr_latency", {31'd0, im_wr}, 32'd1);
        checkOutput("wd_stable", im_wd, w);
    endtask

    task automatic startLoad(input int len);
        start    = 1'b1;
        load_len = LEN_W'(len);
        exp_sum  = '0;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            if (done !== 1'b1) checkOutput("hold_load", {31'd0, cpu_hold}, 32'd1);
            n++;
        end
        checkOutput("done", {31'd0, done}, 32'd1);
    endtask

    task automatic applyStimulus(input int len, input int gap, input int pulse_word);
        logic [31:0] w;
        startLoad(len);
        checkOutput("st_busy", {31'd0, busy},       32'd1);
        checkOutput("st_rdy",  {31'd0, byte_ready}, 32'd1);
        checkOutput("st_hold", {31'd0, cpu_hold},   32'd1);
        checkOutput("st_done", {31'd0, done},       32'd0);
        checkOutput("st_err",  {31'd0, err},        32'd0);
        checkOutput("st_sum",  checksum,            32'd0);
        for (int i = 0; i < len; i++) begin
            if (i == pulse_word) begin
                tick();
                start    = 1'b1;
                load_len = LEN_W'(1);
                tick();
                start = 1'b0;
                checkOutput("ign_busy", {31'd0, busy},       32'd1);
                checkOutput("ign_rdy",  {31'd0, byte_ready}, 32'd1);
            end
            w = (data_src.size() > 0) ? data_src.pop_front() : $urandom();
            sb.push_back('{addr: ADDR_W'(i), data: w});
            exp_sum ^= w;
            sendWord(w, gap);
        end
        waitDone();
        checkOutput("sum",      checksum,                    exp_sum);
        checkOutput("addr_end", {24'd0, im_addr},            {24'd0, ADDR_W'(len)});
        checkOutput("hold_dn",  {31'd0, cpu_hold},           32'd0);
        checkOutput("busy_dn",  {31'd0, busy},               32'd0);
        checkOutput("sb_empty", sb.size(),                   32'd0);
    endtask

    initial begin
        int ws;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("rst");
        rst_n = 1'b1;
        tick();

        $display("[TB] two-word load");
        data_src.push_back(32'h8C010004);
        data_src.push_back(32'hAC020008);
        applyStimulus(2, 0, -1);

        $display("[TB] single word with gapped bytes");
        applyStimulus(1, 3, -1);

        $display("[TB] abort mid-word then restart");
        ws = writes_seen;
        startLoad(3);
        sendByte(8'h11);
        sendByte(8'h22);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checkOutput("ab_busy", {31'd0, busy},       32'd0);
        checkOutput("ab_done", {31'd0, done},       32'd0);
        checkOutput("ab_rdy",  {31'd0, byte_ready}, 32'd0);
        checkOutput("ab_hold", {31'd0, cpu_hold},   32'd1);
        repeat (5) tick();
        checkOutput("ab_no_wr", writes_seen - ws, 32'd0);
        applyStimulus(1, 0, -1);

        $display("[TB] zero and oversize lengths");
        startLoad(0);
        checkOutput("z_done", {31'd0, done},       32'd1);
        checkOutput("z_busy", {31'd0, busy},       32'd0);
        checkOutput("z_hold", {31'd0, cpu_hold},   32'd0);
        checkOutput("z_rdy",  {31'd0, byte_ready}, 32'd0);
        checkOutput("z_sum",  checksum,            32'd0);
        ws = writes_seen;
        startLoad(257);
        checkOutput("e_err",  {31'd0, err},      32'd1);
        checkOutput("e_done", {31'd0, done},     32'd0);
        checkOutput("e_busy", {31'd0, busy},     32'd0);
        checkOutput("e_hold", {31'd0, cpu_hold}, 32'd1);
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        repeat (4) begin
            @(negedge clk);
            checkOutput("e_rdy", {31'd0, byte_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        checkOutput("e_no_wr", writes_seen - ws, 32'd0);

        $display("[TB] full 256-word image");
        ws = writes_seen;
        applyStimulus(256, 0, 10);
        checkOutput("full_wrs", writes_seen - ws, 32'd256);

        $display("[TB] async reset during write");
        startLoad(1);
        sendWord(32'hDEADBEEF, 0);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetValues("arst");
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
